// File: rtl/pc_stack_param.sv
// Program-counter stack: serially increments the top PC over the fetch cycles, then applies push/pop.
// Single-cycle state update; halt freezes all state, and outputs are combinational from the top slot.
module pc_stack_param #(
  parameter int WORD_W     = 4,
  parameter int ADDR_WORDS = 3,
  parameter int DEPTH      = 4,
  parameter int SATURATE   = 0,
  parameter int CYCLE_W    = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          halt,
  input  logic [CYCLE_W-1:0]            cycle,
  input  logic [1:0]                    control,
  input  logic [1:0]                    pc_next_sel,
  input  logic [WORD_W-1:0]             data,
  input  logic [WORD_W-1:0]             regval,
  input  logic [WORD_W-1:0]             inst_operand,
  input  logic [ADDR_WORDS-1:0]         pc_write_enable,
  input  logic                          load_en,
  input  logic [WORD_W*ADDR_WORDS-1:0]  target,
  input  logic                          error_clear,
  output logic [WORD_W*ADDR_WORDS-1:0]  pc,
  output logic                          pc_enable,
  output logic [WORD_W-1:0]             pc_word,
  output logic [$clog2(DEPTH+1)-1:0]    depth,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PC_W  = WORD_W * ADDR_WORDS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   FULL = CNT_W'(DEPTH);
  localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(ADDR_WORDS - 1);

  logic [PC_W-1:0]   slots [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              unf;

  logic              fetch;
  logic              last;
  logic [PC_W-1:0]   top;
  logic [PC_W-1:0]   top_nxt;
  logic              carry_nxt;
  logic [WORD_W-1:0] src;
  logic [WORD_W:0]   sum;
  logic              found;

  assign fetch     = cycle < CYCLE_W'(ADDR_WORDS);
  assign last      = cycle == LAST;
  assign top       = slots[idx];
  assign pc        = top;
  assign pc_enable = fetch;
  assign depth     = count;
  assign overflow  = ovf;
  assign underflow = unf;

  always_comb begin
    case (pc_next_sel)
      2'b00:   src = data;
      2'b01:   src = regval;
      2'b10:   src = inst_operand;
      default: src = '0;
    endcase
  end

  // Next value of the top slot: serial increment while fetching, word write or full load otherwise.
  always_comb begin
    top_nxt   = top;
    carry_nxt = carry;
    sum       = '0;
    found     = 1'b0;
    pc_word   = '0;
    if (fetch) begin
      for (int k = 0; k < ADDR_WORDS; k++) begin
        if (cycle == CYCLE_W'(k)) begin
          pc_word = top[k*WORD_W +: WORD_W];
          sum = {1'b0, top[k*WORD_W +: WORD_W]} +
                ((k == 0) ? (WORD_W+1)'(1) : (WORD_W+1)'(carry));
          top_nxt[k*WORD_W +: WORD_W] = sum[WORD_W-1:0];
          carry_nxt = sum[WORD_W];
        end
      end
    end else if ((|pc_write_enable) && (pc_next_sel != 2'b11)) begin
      for (int k = 0; k < ADDR_WORDS; k++) begin
        if (pc_write_enable[k] && !found) begin
          found = 1'b1;
          top_nxt[k*WORD_W +: WORD_W] = src;
        end
      end
    end else if (load_en) begin
      top_nxt = target;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) slots[s] <= '0;
      idx   <= '0;
      carry <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (!halt) begin
      slots[idx] <= top_nxt;
      carry      <= carry_nxt;
      if (error_clear) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      // Stack op lands after the final increment; the increment above still targets the pre-op slot.
      if (last) begin
        case (control)
          2'b01: begin
            if (count != FULL) begin
              idx   <= idx + 1'b1;
              count <= count + 1'b1;
            end else begin
              ovf <= 1'b1;
              if (SATURATE == 0) idx <= idx + 1'b1;
            end
          end
          2'b10: begin
            if (count != '0) begin
              idx   <= idx - 1'b1;
              count <= count - 1'b1;
            end else begin
              unf <= 1'b1;
              if (SATURATE == 0) idx <= idx - 1'b1;
            end
          end
          2'b11:   unf <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_param.sv
// Bench for pc_stack_param: wrap (instance 0) and saturate (instance 1) stacks driven in lockstep.
module tb_pc_stack_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic [2:0]  cycle = 3'd7;
  logic [1:0]  control = 2'b00;
  logic [1:0]  pc_next_sel = 2'b00;
  logic [3:0]  data = 4'h3;
  logic [3:0]  regval = 4'hA;
  logic [3:0]  inst_operand = 4'h7;
  logic [2:0]  pc_write_enable = 3'b000;
  logic        load_en = 1'b0;
  logic [11:0] target = 12'h000;
  logic        error_clear = 1'b0;

  logic [11:0] pc_o  [2];
  logic        pen_o [2];
  logic [3:0]  pw_o  [2];
  logic [2:0]  dep_o [2];
  logic        ov_o  [2];
  logic        un_o  [2];

  int tests = 0;
  int fails = 0;

  pc_stack_param #(.WORD_W(4), .ADDR_WORDS(3), .DEPTH(4), .SATURATE(0), .CYCLE_W(3)) u0 (
    .clock(clock), .reset_n(reset_n), .halt(halt), .cycle(cycle), .control(control),
    .pc_next_sel(pc_next_sel), .data(data), .regval(regval), .inst_operand(inst_operand),
    .pc_write_enable(pc_write_enable), .load_en(load_en), .target(target),
    .error_clear(error_clear), .pc(pc_o[0]), .pc_enable(pen_o[0]), .pc_word(pw_o[0]),
    .depth(dep_o[0]), .overflow(ov_o[0]), .underflow(un_o[0]));

  pc_stack_param #(.WORD_W(4), .ADDR_WORDS(3), .DEPTH(4), .SATURATE(1), .CYCLE_W(3)) u1 (
    .clock(clock), .reset_n(reset_n), .halt(halt), .cycle(cycle), .control(control),
    .pc_next_sel(pc_next_sel), .data(data), .regval(regval), .inst_operand(inst_operand),
    .pc_write_enable(pc_write_enable), .load_en(load_en), .target(target),
    .error_clear(error_clear), .pc(pc_o[1]), .pc_enable(pen_o[1]), .pc_word(pw_o[1]),
    .depth(dep_o[1]), .overflow(ov_o[1]), .underflow(un_o[1]));

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the whole instruction's effect is "top PC + 1"; after fetch cycle k the low k+1 words
  // of the top slot already hold the incremented value.
  logic [11:0] m_slot [2][4];
  logic [11:0] m_inc  [2];
  int          m_idx  [2];
  int          m_dep  [2];
  logic        m_ov   [2];
  logic        m_un   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 4; s++) m_slot[i][s] = '0;
      m_inc[i] = '0;
      m_idx[i] = 0;
      m_dep[i] = 0;
      m_ov[i]  = 1'b0;
      m_un[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [11:0] top;
    logic [3:0]  w;
    int          lm;
    int          j;
    for (int i = 0; i < 2; i++) begin
      top = m_slot[i][m_idx[i]];
      if (cycle < 3) begin
        if (cycle == 0) m_inc[i] = top + 12'd1;
        lm  = (1 << ((int'(cycle) + 1) * 4)) - 1;
        top = (m_inc[i] & lm[11:0]) | (top & ~lm[11:0]);
      end else if (pc_write_enable != 0 && pc_next_sel != 2'b11) begin
        j = 0;
        while (!pc_write_enable[j]) j++;
        w = (pc_next_sel == 2'b00) ? data : (pc_next_sel == 2'b01) ? regval : inst_operand;
        top[j*4 +: 4] = w;
      end else if (load_en) begin
        top = target;
      end
      m_slot[i][m_idx[i]] = top;
      if (error_clear) begin
        m_ov[i] = 1'b0;
        m_un[i] = 1'b0;
      end
      if (cycle == 2) begin
        if (control == 2'b01) begin
          if (m_dep[i] < 4) begin
            m_idx[i] = (m_idx[i] + 1) % 4;
            m_dep[i]++;
          end else begin
            m_ov[i] = 1'b1;
            if (i == 0) m_idx[i] = (m_idx[i] + 1) % 4;
          end
        end else if (control == 2'b10) begin
          if (m_dep[i] > 0) begin
            m_idx[i] = (m_idx[i] + 3) % 4;
            m_dep[i]--;
          end else begin
            m_un[i] = 1'b1;
            if (i == 0) m_idx[i] = (m_idx[i] + 3) % 4;
          end
        end else if (control == 2'b11) begin
          m_un[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else if (!halt) model_step();
    end
  end

  // Cycle-by-cycle comparison, sampled well clear of the rising edge.
  initial begin
    logic [11:0] t;
    forever begin
      @(negedge clock);
      #3;
      for (int i = 0; i < 2; i++) begin
        t = m_slot[i][m_idx[i]];
        chk($sformatf("pc[%0d]", i), pc_o[i], t);
        chk($sformatf("depth[%0d]", i), dep_o[i], m_dep[i]);
        chk($sformatf("overflow[%0d]", i), ov_o[i], m_ov[i]);
        chk($sformatf("underflow[%0d]", i), un_o[i], m_un[i]);
        chk($sformatf("pc_enable[%0d]", i), pen_o[i], cycle < 3);
        t = (cycle < 3) ? (t >> (4 * cycle)) : 12'h000;
        chk($sformatf("pc_word[%0d]", i), pw_o[i], t[3:0]);
      end
    end
  end

  task automatic step(input logic [2:0] c, input logic [1:0] ctl, input logic [2:0] pwe,
                      input logic [1:0] sel, input logic ld, input logic [11:0] tgt,
                      input logic clr, input logic h);
    @(negedge clock);
    cycle = c; control = ctl; pc_write_enable = pwe; pc_next_sel = sel;
    load_en = ld; target = tgt; error_clear = clr; halt = h;
  endtask

  task automatic idle(input logic [2:0] c);
    step(c, 2'b00, 3'b000, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic instr(input logic [1:0] ctl);
    for (int c = 0; c < 8; c++) step(3'(c), ctl, 3'b000, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic push_load(input logic ld, input logic [11:0] tgt);
    idle(0); idle(1);
    step(2, 2'b01, 3'b000, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
    idle(3);
    step(4, 2'b00, 3'b000, 2'b00, ld, tgt, 1'b0, 1'b0);
    idle(5); idle(6); idle(7);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    cycle = 3'd7;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    logic h;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_pc", pc_o[0], 12'h000);
    chk("reset_depth", dep_o[0], 3'd0);
    chk("reset_flags", {ov_o[0], un_o[0], ov_o[1], un_o[1]}, 4'b0000);
    reset_n = 1'b1;

    // Plain counting, including the carry from word 0 into word 1.
    repeat (15) instr(2'b00);
    #1 chk("count15", pc_o[0], 12'h00F);
    idle(0); idle(1);
    #1 chk("carry_pending", pc_o[0], 12'h000);
    for (int k = 2; k < 8; k++) idle(3'(k));
    #1 chk("count16", pc_o[0], 12'h010);

    // All-ones wraps to zero with no flag.
    step(4, 2'b00, 3'b000, 2'b00, 1'b1, 12'hFFF, 1'b0, 1'b0);
    idle(7);
    #1 chk("load_fff", pc_o[0], 12'hFFF);
    instr(2'b00);
    #1 chk("wrap_pc", pc_o[0], 12'h000);
    chk("wrap_flags", {ov_o[0], un_o[0]}, 2'b00);

    // Push then load, then pop back to the incremented old slot.
    push_load(1'b1, 12'h123);
    #1 chk("push_depth", dep_o[0], 3'd1);
    chk("push_pc", pc_o[0], 12'h123);
    instr(2'b10);
    #1 chk("pop_depth", dep_o[0], 3'd0);
    chk("pop_pc", pc_o[0], 12'h001);

    // Fill the stack, then one push too many.
    for (int n = 1; n <= 4; n++) push_load(1'b1, 12'(n * 'h100));
    #1 chk("full_depth", dep_o[0], 3'd4);
    chk("full_ovf", ov_o[0], 1'b0);
    push_load(1'b0, 12'h000);
    #1 chk("ovf_depth0", dep_o[0], 3'd4);
    chk("ovf_depth1", dep_o[1], 3'd4);
    chk("ovf_flags", {ov_o[0], ov_o[1]}, 2'b11);
    chk("ovf_wrap_pc", pc_o[0], 12'h101);
    chk("ovf_sat_pc", pc_o[1], 12'h401);

    // Underflow: set beats a simultaneous clear; a later clear drops it.
    do_reset();
    idle(0); idle(1);
    step(2, 2'b10, 3'b000, 2'b00, 1'b0, 12'h000, 1'b1, 1'b0);
    step(3, 2'b00, 3'b000, 2'b00, 1'b0, 12'h000, 1'b1, 1'b0);
    #1 chk("unf_set", {un_o[0], un_o[1]}, 2'b11);
    chk("unf_depth", dep_o[0], 3'd0);
    idle(4);
    #1 chk("unf_clear", {un_o[0], un_o[1]}, 2'b00);
    idle(5); idle(6); idle(7);
    #1 chk("unf_wrap_pc", pc_o[0], 12'h000);
    chk("unf_sat_pc", pc_o[1], 12'h001);
    instr(2'b11);
    #1 chk("reserved_unf", un_o[0], 1'b1);
    step(7, 2'b00, 3'b000, 2'b00, 1'b0, 12'h000, 1'b1, 1'b0);
    idle(7);
    #1 chk("reserved_clear", un_o[0], 1'b0);

    // Word writes beat load_en; selector 11 falls through to the load.
    do_reset();
    idle(0); idle(1); idle(2); idle(3);
    step(4, 2'b00, 3'b110, 2'b01, 1'b1, 12'h5C3, 1'b0, 1'b0);
    idle(5);
    #1 chk("word_write", pc_o[0], 12'h0A1);
    step(6, 2'b00, 3'b001, 2'b11, 1'b1, 12'h5C3, 1'b0, 1'b0);
    idle(7);
    #1 chk("sel11_load", pc_o[0], 12'h5C3);

    // Halt freezes the PC and the sticky flag, even against error_clear.
    idle(0); idle(1);
    step(2, 2'b11, 3'b000, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
    step(3, 2'b00, 3'b000, 2'b00, 1'b0, 12'h000, 1'b1, 1'b1);
    step(4, 2'b00, 3'b001, 2'b00, 1'b1, 12'h111, 1'b0, 1'b1);
    idle(5);
    #1 chk("halt_pc", pc_o[0], 12'h5C4);
    chk("halt_unf", un_o[0], 1'b1);
    data = 4'h9;
    inst_operand = 4'hE;
    step(6, 2'b00, 3'b100, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
    step(7, 2'b00, 3'b010, 2'b10, 1'b0, 12'h000, 1'b0, 1'b0);
    idle(0);
    #1 chk("data_inst_write", pc_o[0], 12'h9E4);
    for (int k = 1; k < 8; k++) idle(3'(k));

    // Asynchronous reset in the middle of a fetch.
    instr(2'b01);
    idle(0); idle(1);
    #1 chk("pre_reset", {dep_o[0], un_o[0]}, 4'b0011);
    #1 reset_n = 1'b0;
    #1 chk("async_pc", pc_o[0], 12'h000);
    chk("async_depth", dep_o[0], 3'd0);
    chk("async_flags", {ov_o[0], un_o[0]}, 2'b00);
    chk("async_word", pw_o[0], 4'h0);
    @(negedge clock);
    cycle = 3'd7;
    reset_n = 1'b1;

    // Pseudo-random instruction stream; cycle is held while halted.
    for (int n = 0; n < 40; n++) begin
      c = 0;
      while (c < 8) begin
        h = ($urandom_range(0, 7) == 0);
        data = 4'($urandom);
        regval = 4'($urandom);
        inst_operand = 4'($urandom);
        step(3'(c), 2'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
             12'($urandom), $urandom_range(0, 7) == 0, h);
        if (!h) c++;
      end
    end
    idle(7);
    idle(7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
